escalonador_zonas: RTL and testbench
====================================

ESCALONADOR_ZONAS -- requirements
Module: escalonador_zonas

Interface
REQ-001 SHALL have parameter N_ZONAS, default 4, number of lighting zones (legal 2..8).
REQ-002 SHALL have parameter MAX_ATIVAS, default 2, maximum simultaneously granted zones (legal 1..N_ZONAS).
REQ-003 SHALL have parameter MIN_ON_T, default 5000, minimum held cycles before a grant is preemptible (legal >= 1).
REQ-004 SHALL have port clk  input  1  1 kHz system clock (the divided clock the zone controllers use).
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  N_ZONAS  per-zone lamp request (zone controller lamp output).
REQ-007 SHALL have port manual  input  N_ZONAS  per-zone manual-mode flag; marks a request as high priority.
REQ-008 SHALL have port grant  output  N_ZONAS  per-zone lamp power enable, registered.
REQ-009 SHALL have port pendente  output  N_ZONAS  req AND NOT grant, combinational.
REQ-010 SHALL have port ativas  output  4  count of set bits in grant, registered.

Function
REQ-011 SHALL keep popcount(grant) <= MAX_ATIVAS in every cycle.
REQ-012 SHALL clear grant[i] at the first clk edge sampling req[i]=0 (1-cycle release latency), regardless of hold time.
REQ-013 SHALL set grant[i] only when req[i]=1, and only at an edge where post-release count < MAX_ATIVAS.
REQ-014 SHALL set at most one new grant bit per edge (inrush limiting).
REQ-015 SHALL free a slot released at an edge for a new grant at that same edge.
REQ-016 SHALL select the new grant by round-robin from pointer ptr, first among pending zones with manual=1, else among all pending zones.
REQ-017 SHALL set ptr to (i+1) mod N_ZONAS after granting zone i; ptr SHALL be unchanged on edges with no new grant.
REQ-018 SHALL keep a per-zone hold counter: cleared when grant[i] sets, incremented while grant[i]=1, saturating at MIN_ON_T.
REQ-019 SHALL run a 3-state FSM: LIVRE (count < MAX_ATIVAS), CHEIO (count = MAX_ATIVAS), REVOGA (one-cycle preemption).
REQ-020 SHALL transition CHEIO->REVOGA when preemption is enabled, a pending zone has manual=1, and at least one granted zone has manual=0 with hold counter = MIN_ON_T.
REQ-021 SHALL clear, in REVOGA, the grant of the lowest-index eligible victim and then return to LIVRE; the manual zone SHALL be granted at the following edge by REQ-016.
REQ-022 SHALL abort REVOGA without revoking if the triggering manual request drops in the same cycle.
REQ-023 SHALL never revoke a zone with manual=1, nor one whose hold counter < MIN_ON_T.
REQ-024 SHALL update ativas at the same edge as grant.

Reset
REQ-025 SHALL on rst=1, asynchronously, force grant=0, ativas=0, ptr=0, all hold counters=0, FSM=LIVRE.
REQ-026 SHALL produce no grant at the first edge after rst deasserts; requests SHALL be evaluated from the second edge.
REQ-027 SHALL discard any in-progress REVOGA on reset mid-operation.

Configuration
REQ-028 SHALL implement preemption only when macro ESCALONADOR_PREEMPCAO_EN is defined.
REQ-029 SHALL, without ESCALONADOR_PREEMPCAO_EN, omit REVOGA and hold counters; manual requests SHALL have queue priority only (REQ-016).

Verification (N_ZONAS=4, MAX_ATIVAS=2, MIN_ON_T=8)
REQ-030 SHALL cover: req=1111 from idle -> grant 0001, 0011 on successive edges, then constant; pendente=1100; ativas=2.
REQ-031 SHALL cover: grant=0011, req drops to 1110 -> next edge grant=0110 (release and new grant same edge), ptr=3.
REQ-032 SHALL cover: grant=0011 manual=0000 held 8 cycles, req[3]=1 manual[3]=1 (macro defined) -> REVOGA clears bit0, next edge grant=1010.
REQ-033 SHALL cover: same as REQ-032 but hold=5 -> no revocation until hold reaches 8; without macro -> grant stays 0011 indefinitely.
REQ-034 SHALL cover: rst pulsed during REVOGA with grant=0011 -> grant=0000, ativas=0 immediately; first grant two edges after release.
REQ-035 SHALL cover: req=0101 manual=0100 from idle, ptr=0 -> grant 0100 first, then 0101.

Source files
------------

// File: rtl/escalonador_zonas.sv
// rtl/escalonador_zonas.sv - lighting zone power scheduler with round-robin grants and a cap on active zones
// Manual-priority preemption of long-held grants exists only when ESCALONADOR_PREEMPCAO_EN is defined.
module escalonador_zonas #(
    parameter int N_ZONAS    = 4,
    parameter int MAX_ATIVAS = 2,
    parameter int MIN_ON_T   = 5000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_ZONAS-1:0] req,
    input  logic [N_ZONAS-1:0] manual,
    output logic [N_ZONAS-1:0] grant,
    output logic [N_ZONAS-1:0] pendente,
    output logic [3:0]         ativas
);
    localparam int PW = $clog2(N_ZONAS);
    localparam logic [3:0] MAX_CNT = 4'(MAX_ATIVAS);

    typedef enum logic [1:0] {LIVRE, CHEIO, REVOGA} estado_t;

    estado_t            estado_q, estado_d;
    logic [N_ZONAS-1:0] grant_q, grant_d;
    logic [3:0]         ativas_q, ativas_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic               armado_q;

    logic [N_ZONAS-1:0] mantidos, pend, pend_man, cand;
    logic [3:0]         cnt_mantidos;
    logic               achou, concede;
    logic [PW-1:0]      sel;

    function automatic logic [3:0] popcnt(input logic [N_ZONAS-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < N_ZONAS; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    // Releases take effect before the new grant is chosen, so a freed slot is reusable at once.
    always_comb begin : selecao
        mantidos     = grant_q & req;
        pend         = req & ~grant_q;
        pend_man     = pend & manual;
        cand         = (pend_man != '0) ? pend_man : pend;
        cnt_mantidos = popcnt(mantidos);
        achou        = 1'b0;
        sel          = '0;
        for (int k = 0; k < N_ZONAS; k++) begin
            logic [PW-1:0] idx;
            idx = PW'((int'(ptr_q) + k) % N_ZONAS);
            if (!achou && cand[idx]) begin
                achou = 1'b1;
                sel   = idx;
            end
        end
    end

`ifdef ESCALONADOR_PREEMPCAO_EN
    localparam int HW = $clog2(MIN_ON_T + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_ON_T);

    logic [HW-1:0]      hold_q [N_ZONAS];
    logic [N_ZONAS-1:0] hold_cheio, eleg;
    logic [PW-1:0]      vitima;
    logic               gatilho;

    // Only automatic zones that have been on for the full minimum time may be revoked.
    always_comb begin : preempcao
        hold_cheio = '0;
        for (int i = 0; i < N_ZONAS; i++) hold_cheio[i] = (hold_q[i] == HOLD_MAX);
        eleg    = mantidos & ~manual & hold_cheio;
        gatilho = (pend_man != '0) && (eleg != '0);
        vitima  = '0;
        for (int i = N_ZONAS - 1; i >= 0; i--) begin
            if (eleg[i]) vitima = PW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ZONAS; i++) hold_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_ZONAS; i++) begin
                if (!grant_d[i] || !grant_q[i]) hold_q[i] <= '0;
                else if (hold_q[i] != HOLD_MAX) hold_q[i] <= hold_q[i] + 1'b1;
            end
        end
    end
`endif

    always_comb begin : proximo
        concede = armado_q && (estado_q != REVOGA) && (cnt_mantidos < MAX_CNT) && achou;
        grant_d = mantidos;
        ptr_d   = ptr_q;
        if (concede) begin
            grant_d[sel] = 1'b1;
            ptr_d        = (sel == PW'(N_ZONAS - 1)) ? '0 : sel + 1'b1;
        end
`ifdef ESCALONADOR_PREEMPCAO_EN
        if (estado_q == REVOGA && gatilho) grant_d[vitima] = 1'b0;
`endif
        ativas_d = popcnt(grant_d);
        estado_d = (ativas_d >= MAX_CNT) ? CHEIO : LIVRE;
`ifdef ESCALONADOR_PREEMPCAO_EN
        if (estado_q == CHEIO && gatilho && cnt_mantidos == MAX_CNT) estado_d = REVOGA;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q  <= '0;
            ativas_q <= '0;
            ptr_q    <= '0;
            armado_q <= 1'b0;
            estado_q <= LIVRE;
        end else begin
            grant_q  <= grant_d;
            ativas_q <= ativas_d;
            ptr_q    <= ptr_d;
            armado_q <= 1'b1;
            estado_q <= estado_d;
        end
    end

    assign grant    = grant_q;
    assign ativas   = ativas_q;
    assign pendente = req & ~grant_q;
endmodule

// File: tb/tb_escalonador_zonas.sv
// tb/tb_escalonador_zonas.sv - directed scoreboard bench for escalonador_zonas (N_ZONAS=4, MAX_ATIVAS=2, MIN_ON_T=8)
module tb_escalonador_zonas;
`ifdef ESCALONADOR_PREEMPCAO_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] req, manual, grant, pendente, ativas;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] a;
        logic [3:0] p;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];
    int    checks   = 0;
    int    failures = 0;

    escalonador_zonas #(.N_ZONAS(4), .MAX_ATIVAS(2), .MIN_ON_T(8)) dut (
        .clk(clk), .rst(rst), .req(req), .manual(manual),
        .grant(grant), .pendente(pendente), .ativas(ativas)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compare_out();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (grant === e.g) else begin
            failures++;
            $error("FAIL %s grant got=%b exp=%b", t, grant, e.g);
        end
        checks++;
        assert (ativas === e.a) else begin
            failures++;
            $error("FAIL %s ativas got=%0d exp=%0d", t, ativas, e.a);
        end
        checks++;
        assert (pendente === e.p) else begin
            failures++;
            $error("FAIL %s pendente got=%b exp=%b", t, pendente, e.p);
        end
    endtask

    task automatic now_check(input logic [3:0] g, a, p, input string t);
        exp_q.push_back('{g, a, p});
        tag_q.push_back(t);
        compare_out();
    endtask

    task automatic step(input logic [3:0] r, m, g, a, p, input string t);
        req    = r;
        manual = m;
        exp_q.push_back('{g, a, p});
        tag_q.push_back(t);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        rst    = 1'b1;
        req    = 4'b0000;
        manual = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        now_check(4'b0000, 4'd0, 4'b0000, "reset");
        step(4'b1111, 4'b0000, 4'b0000, 4'd0, 4'b1111, "rst_hold");
        rst = 1'b0;

        // fill from idle; the first edge after reset never grants
        step(4'b1111, 4'b0000, 4'b0000, 4'd0, 4'b1111, "first_edge");
        step(4'b1111, 4'b0000, 4'b0001, 4'd1, 4'b1110, "fill_1");
        step(4'b1111, 4'b0000, 4'b0011, 4'd2, 4'b1100, "fill_2");
        step(4'b1111, 4'b0000, 4'b0011, 4'd2, 4'b1100, "fill_const");

        // release and new grant on the same edge, then pointer wrap
        step(4'b1110, 4'b0000, 4'b0110, 4'd2, 4'b1000, "rel_new");
        step(4'b1100, 4'b0000, 4'b1100, 4'd2, 4'b0000, "ptr_wrap");
        step(4'b0000, 4'b0000, 4'b0000, 4'd0, 4'b0000, "release_all");

        // manual request has queue priority
        step(4'b0101, 4'b0100, 4'b0100, 4'd1, 4'b0001, "man_first");
        step(4'b0101, 4'b0100, 4'b0101, 4'd2, 4'b0000, "man_then");
        step(4'b0000, 4'b0000, 4'b0000, 4'd0, 4'b0000, "idle_2");

        // zone 1 manual (never revocable), zone 0 revocable only once hold reaches 8
        step(4'b0011, 4'b0010, 4'b0010, 4'd1, 4'b0001, "hold_a");
        step(4'b0011, 4'b0010, 4'b0011, 4'd2, 4'b0000, "hold_b");
        for (int k = 1; k <= 12; k++) begin
            logic [3:0] g, a, p;
            if (PRE && k == 10) begin
                g = 4'b0010; a = 4'd1; p = 4'b1001;
            end else if (PRE && k >= 11) begin
                g = 4'b1010; a = 4'd2; p = 4'b0001;
            end else begin
                g = 4'b0011; a = 4'd2; p = 4'b1000;
            end
            step(4'b1011, 4'b1010, g, a, p, $sformatf("hold_%0d", k));
        end
        step(4'b0000, 4'b0000, 4'b0000, 4'd0, 4'b0000, "idle_3");

        // both automatic, fully held; abort then real preemption of zone 0
        step(4'b0011, 4'b0000, PRE ? 4'b0001 : 4'b0010, 4'd1, PRE ? 4'b0010 : 4'b0001, "pre_a");
        step(4'b0011, 4'b0000, 4'b0011, 4'd2, 4'b0000, "pre_b");
        for (int k = 1; k <= 8; k++)
            step(4'b0011, 4'b0000, 4'b0011, 4'd2, 4'b0000, $sformatf("pre_hold_%0d", k));
        step(4'b1011, 4'b1000, 4'b0011, 4'd2, 4'b1000, "revoga_enter");
        step(4'b0011, 4'b0000, 4'b0011, 4'd2, 4'b0000, "revoga_abort");
        step(4'b1011, 4'b1000, 4'b0011, 4'd2, 4'b1000, "revoga_again");
        step(4'b1011, 4'b1000, PRE ? 4'b0010 : 4'b0011, PRE ? 4'd1 : 4'd2,
             PRE ? 4'b1001 : 4'b1000, "revoga_clear");
        step(4'b1011, 4'b1000, PRE ? 4'b1010 : 4'b0011, 4'd2,
             PRE ? 4'b0001 : 4'b1000, "revoga_grant");
        step(4'b0000, 4'b0000, 4'b0000, 4'd0, 4'b0000, "idle_4");

        // reset in the middle of a preemption
        step(4'b0011, 4'b0000, PRE ? 4'b0001 : 4'b0010, 4'd1, PRE ? 4'b0010 : 4'b0001, "rp_a");
        step(4'b0011, 4'b0000, 4'b0011, 4'd2, 4'b0000, "rp_b");
        for (int k = 1; k <= 8; k++)
            step(4'b0011, 4'b0000, 4'b0011, 4'd2, 4'b0000, $sformatf("rp_hold_%0d", k));
        step(4'b1011, 4'b1000, 4'b0011, 4'd2, 4'b1000, "rp_revoga");
        rst = 1'b1;
        #1;
        now_check(4'b0000, 4'd0, 4'b1011, "rst_async");
        step(4'b1011, 4'b1000, 4'b0000, 4'd0, 4'b1011, "rst_edge");
        rst = 1'b0;
        step(4'b1011, 4'b1000, 4'b0000, 4'd0, 4'b1011, "post_rst_1");
        step(4'b1011, 4'b1000, 4'b1000, 4'd1, 4'b0011, "post_rst_2");
        step(4'b1011, 4'b1000, 4'b1001, 4'd2, 4'b0010, "post_rst_3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
